// File: rtl/fifo_tx_serializer_pkg.sv
// Shared types and defaults for the FIFO-fed serial transmitter.
package fifo_tx_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DEF_WL           = 8;
    localparam int DEF_CLKS_PER_BIT = 4;
    localparam int FRAME_CNT_W      = 16;

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Per-bit down-counter: holds 0 while cleared, then runs CLKS_PER_BIT-1 .. 1
// and ticks on 1, so every bit period is exactly CLKS_PER_BIT cycles.
module bit_timer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (count == '0) begin
            count <= TW'(CLKS_PER_BIT - 1);
        end else begin
            count <= count - TW'(1);
        end
    end

    assign tick = (count == TW'(1));

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pulls one word per frame from an upstream FIFO and sends it as a
// start/data(LSB first)/stop serial frame; outputs are decoded from state.
module fifo_tx_serializer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int WL           = DEF_WL,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [WL-1:0]          fifo_data,
    output logic                   fifo_read_rq,
    output logic                   tx_serial,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int IW = $clog2(WL + 1);

    state_t                 state, state_next;
    logic [WL-1:0]          shreg;
    logic [IW-1:0]          bit_idx;
    logic [FRAME_CNT_W-1:0] done_count;
    logic                   tick;
    logic                   timer_clr;
    logic                   last_bit;
    logic                   stop_end;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .tick (tick)
    );

    assign last_bit = (bit_idx == IW'(WL - 1));
    assign stop_end = (state == STOP) && tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fifo_read_rq = 1'b0;
        tx_serial    = 1'b1;
        busy         = (state != IDLE);
        unique case (state)
            IDLE:  if (enable && !fifo_empty) state_next = REQ;
            REQ: begin
                fifo_read_rq = 1'b1;
                state_next   = LOAD;
            end
            LOAD:  state_next = START;
            START: begin
                tx_serial = 1'b0;
                if (tick) state_next = DATA;
            end
            DATA: begin
                tx_serial = shreg[0];
                if (tick && last_bit) state_next = STOP;
            end
            STOP:  if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Untimed states keep the timer parked at zero so each timed state starts fresh.
        timer_clr = (state_next != state) || (state inside {IDLE, REQ, LOAD});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
            done_count <= '0;
        end else begin
            frame_done <= stop_end;
            if (stop_end) begin
                done_count <= done_count + FRAME_CNT_W'(1);
            end
            // FIFO read data is valid during LOAD, one cycle after the request.
            if (state == LOAD) begin
                shreg <= fifo_data;
            end else if (state == DATA && tick) begin
                shreg <= shreg >> 1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + IW'(1);
            end
        end
    end

    assign frame_count = done_count;

endmodule
